// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: samples an incoming HS/VS/RGB stream and measures the
// line and frame lengths. Once the timing is stable it locks onto it and
// recovers column, line, display-area and packed 32-bit pixels.
module vga_sync_decoder #(
    parameter int DEEP_COLOR = 1,
    parameter int RES_X      = 640,
    parameter int RES_Y      = 480,
    parameter int H_START    = 48,
    parameter int V_START    = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  HS,
    input  logic                  VS,
    input  logic [DEEP_COLOR-1:0] R,
    input  logic [DEEP_COLOR-1:0] G,
    input  logic [DEEP_COLOR-1:0] B,
    output logic [9:0]            COL,
    output logic [8:0]            LINE,
    output logic                  inDisplayArea,
    output logic [31:0]           pixel,
    output logic                  locked,
    output logic                  frame_start,
    output logic [10:0]           h_total,
    output logic [9:0]            v_total
);

    localparam logic [10:0] H_BEG = 11'(H_START);
    localparam logic [10:0] H_END = 11'(H_START + RES_X);
    localparam logic [9:0]  V_BEG = 10'(V_START);
    localparam logic [9:0]  V_END = 10'(V_START + RES_Y);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // Place a component in the top bits of its byte, zero-filling below.
    function automatic logic [7:0] msb_align(input logic [DEEP_COLOR-1:0] c);
        logic [7:0] b;
        b = '0;
        b[7 -: DEEP_COLOR] = c;
        return b;
    endfunction

    logic                  hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [DEEP_COLOR-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                  hs_fall, hs_rise, vs_fall, vs_rise;
    logic [10:0]           hcnt_q, hcnt_d, hpos_q, hpos_d;
    logic [9:0]            lcnt_q, lcnt_d, vpos_q, vpos_d;
    logic [11:0]           line_len;
    state_t                state_q, state_d;
    logic [10:0]           ref_h_q, ref_h_d, h_total_q, h_total_d;
    logic [9:0]            v_total_q, v_total_d;
    logic                  disp_q, disp_d, frame_start_q, frame_start_d;
    logic [9:0]            col_q, col_d;
    logic [8:0]            line_q, line_d;
    logic [31:0]           pixel_q, pixel_d;

    // Input capture plus one extra delay on the syncs for edge detection.
    always_comb begin
        hs_d      = HS;
        vs_d      = VS;
        r_d       = R;
        g_d       = G;
        b_d       = B;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        hs_fall   = hs_prev_q & ~hs_q;
        hs_rise   = ~hs_prev_q & hs_q;
        vs_fall   = vs_prev_q & ~vs_q;
        vs_rise   = ~vs_prev_q & vs_q;
    end

    // Syncs reset to their idle (high) level so release does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    // Saturating line/frame length counters and sync-relative positions.
    always_comb begin
        hcnt_d   = hs_fall ? '0 : ((hcnt_q == '1) ? hcnt_q : hcnt_q + 11'd1);
        lcnt_d   = vs_fall ? '0 : ((hs_fall && lcnt_q != '1) ? lcnt_q + 10'd1 : lcnt_q);
        hpos_d   = hs_rise ? '0 : ((hpos_q == '1) ? hpos_q : hpos_q + 11'd1);
        vpos_d   = vs_rise ? '0 : ((hs_rise && vpos_q != '1) ? vpos_q + 10'd1 : vpos_q);
        line_len = {1'b0, hcnt_q} + 12'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            lcnt_q <= '0;
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    // Lock FSM: next state, reference line length and latched totals.
    always_comb begin
        state_d   = state_q;
        ref_h_d   = ref_h_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        unique case (state_q)
            SEARCH: begin
                ref_h_d = '0;
                if (vs_fall) state_d = MEASURE;
            end
            MEASURE: begin
                if (hs_fall) begin
                    if (ref_h_q == '0)
                        ref_h_d = line_len[10:0];
                    else if ({1'b0, ref_h_q} != line_len)
                        ref_h_d = '0;
                end
                // The frame check sees this cycle's line update when both edges coincide.
                if (vs_fall) begin
                    if (ref_h_d != '0 && lcnt_q >= V_END && ref_h_d >= H_END) begin
                        h_total_d = ref_h_d;
                        v_total_d = lcnt_q;
                        state_d   = LOCKED;
                    end else begin
                        ref_h_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (hs_fall && line_len != {1'b0, h_total_q}) state_d = SEARCH;
                if (vs_fall && lcnt_q != v_total_q) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        if (hcnt_q == '1 || lcnt_q == '1) state_d = SEARCH;
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            ref_h_q   <= '0;
            h_total_q <= '0;
            v_total_q <= '0;
        end else begin
            state_q   <= state_d;
            ref_h_q   <= ref_h_d;
            h_total_q <= h_total_d;
            v_total_q <= v_total_d;
        end
    end

    // Display area uses next-cycle lock so it drops together with locked.
    always_comb begin
        disp_d        = (state_d == LOCKED) && (hpos_d >= H_BEG) && (hpos_d < H_END) &&
                        (vpos_d >= V_BEG) && (vpos_d < V_END);
        col_d         = col_q;
        line_d        = line_q;
        pixel_d       = '0;
        frame_start_d = 1'b0;
        if (disp_d) begin
            col_d         = 10'(hpos_d - H_BEG);
            line_d        = 9'(vpos_d - V_BEG);
            pixel_d       = {8'h00, msb_align(r_q), msb_align(g_q), msb_align(b_q)};
            frame_start_d = (col_d == '0) && (line_d == '0);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q        <= 1'b0;
            col_q         <= '0;
            line_q        <= '0;
            pixel_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            disp_q        <= disp_d;
            col_q         <= col_d;
            line_q        <= line_d;
            pixel_q       <= pixel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign COL           = col_q;
    assign LINE          = line_q;
    assign inDisplayArea = disp_q;
    assign pixel         = pixel_q;
    assign locked        = (state_q == LOCKED);
    assign frame_start   = frame_start_q;
    assign h_total       = h_total_q;
    assign v_total       = v_total_q;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Samples an incoming HS/VS/RGB stream on the pixel clock, measures line and frame lengths, and locks onto the timing.
- Once locked, recovers COL/LINE/inDisplayArea and emits packed 32-bit pixels.
- Sits between a VGA input (or a generator under loopback test) and a frame-capture or checker block.

Parameters:
- DEEP_COLOR, 1, bits per colour component on R/G/B inputs (1..8)
- RES_X, 640, active pixels per line
- RES_Y, 480, active lines per frame
- H_START, 48, clocks from HS deassertion (rising edge) to first active pixel
- V_START, 33, lines from VS deassertion (rising edge) to first active line

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- HS  in  1  horizontal sync, active low
- VS  in  1  vertical sync, active low
- R  in  DEEP_COLOR  red component
- G  in  DEEP_COLOR  green component
- B  in  DEEP_COLOR  blue component
- COL  out  10  recovered active column, 0..RES_X-1
- LINE  out  9  recovered active line, 0..RES_Y-1
- inDisplayArea  out  1  pixel/COL/LINE valid this cycle
- pixel  out  32  [31:24]=0, [23:16]=R, [15:8]=G, [7:0]=B
- locked  out  1  timing locked
- frame_start  out  1  one-cycle pulse at first active pixel of each frame
- h_total  out  11  latched clocks per line
- v_total  out  10  latched lines per frame

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state SEARCH; all counters 0. Synchronous effect is immediate; release takes effect at the next clk edge.
- Input stage: HS, VS, R, G and B are registered once. Edges are detected on the registered copies.
- hcnt (11-bit):
  - clears on registered HS falling edge, otherwise increments.
  - saturates at 2047; reaching 2047 forces SEARCH (timeout).
- lcnt (10-bit):
  - clears on VS falling edge; increments on each HS falling edge.
  - saturates at 1023; reaching 1023 forces SEARCH.
- hpos: clears on HS rising edge, otherwise increments (saturating).
- vpos: clears on VS rising edge; increments on each HS rising edge.
- State machine:
  - SEARCH: wait for VS falling edge, then go to MEASURE. Set ref_h to 0 (unset).
  - MEASURE:
    - On each HS falling edge, the first completed line count sets ref_h; any later mismatch clears ref_h, which restarts the consistency check.
    - On VS falling edge, if ref_h is set and lcnt ≥ V_START+RES_Y and ref_h ≥ H_START+RES_X: latch h_total=ref_h and v_total=lcnt, then go to LOCKED. Otherwise stay in MEASURE with ref_h cleared.
  - LOCKED:
    - On HS falling edge, if hcnt+1 ≠ h_total, go to SEARCH.
    - On VS falling edge, if lcnt ≠ v_total, go to SEARCH.
    - Simultaneous HS and VS falling edges: both checks apply; either failure goes to SEARCH.
    - locked=1 only in LOCKED.
    - h_total and v_total hold their last latched values after lock loss and update only at the next lock.
- Display area:
  - Active when locked AND H_START ≤ hpos < H_START+RES_X AND V_START ≤ vpos < V_START+RES_Y.
  - Outputs are registered: COL=hpos−H_START and LINE=vpos−V_START are valid in the same cycle as inDisplayArea.
  - pixel carries the RGB that was registered alongside that hpos.
- Latency: 2 clk from an RGB input sample to the corresponding pixel output.
- Outside the active area:
  - inDisplayArea=0; pixel=0.
  - COL and LINE hold their last values.
- Pixel packing: each component is MSB-aligned in its byte with zero fill. Example: DEEP_COLOR=1, R=1 gives pixel[23:16]=8'h80.
- frame_start: one-cycle pulse asserted with inDisplayArea when COL=0 and LINE=0.
- Lock loss mid-line: inDisplayArea drops in the same cycle locked drops.
- No HS at all: timeout to SEARCH after 2047 clocks; locked stays 0.

Test Plan:
- Loopback from the 640x480 generator (800x525 timing), rst_n released → locked=1 by the end of the second VS falling edge; h_total=800, v_total=525.
- Locked, pattern pixel=col⊕line at DEEP_COLOR=8 → 640 inDisplayArea cycles per line and 480 active lines per frame; pixel matches COL/LINE every cycle; exactly one frame_start per frame.
- Locked, one line stretched to 801 clocks → SEARCH next cycle with locked=0 and inDisplayArea=0. Relock after two clean VS edges.
- HS held high for 3000 clocks → SEARCH at hcnt=2047; h_total and v_total unchanged.
- Frame of 500 lines (< V_START+RES_Y=513) during MEASURE → no lock. A following 525-line frame locks.
- rst_n asserted mid-active-line → all outputs 0 asynchronously; after release, normal relock within two frames.
